exe_stage_md: RTL and testbench
===============================

Name: exe_stage_md

Overview:
- Parametrised execute stage for the RISC-V pipeline. Replaces the pure-combinational ALU execute stage.
- Adds three things:
  - a registered output with a valid/ready handshake toward MEM;
  - branch/jump resolution with target computation;
  - an RV32M/RV64M multiply/divide path, where divide is iterative and multi-cycle.
- Sits between the ID/EX register and the MEM stage, and back-pressures ID via in_ready.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- ADDR_W, 32, instruction address width.
- DIV_BITS, 1, quotient bits retired per divide iteration (1 or 2). XLEN must be divisible by DIV_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream holds a valid op
- in_ready  out  1  stage can accept this cycle
- pc  in  ADDR_W  pc of the op
- is_md  in  1  op uses the mul/div path
- alu_op  in  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10; others give 0
- md_op  in  3  RV-M funct3: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
- br_op  in  3  NONE=0 BEQ=1 BNE=2 BLT=3 BGE=4 BLTU=5 BGEU=6 JUMP=7
- data_a  in  XLEN  operand A
- data_b  in  XLEN  operand B
- offset  in  ADDR_W  branch/jump offset
- reg_we_in  in  1  passed through to reg_we
- out_valid  out  1  result register holds a valid op
- out_ready  in  1  downstream accepts
- result  out  XLEN  ALU or mul/div result
- reg_we  out  1  registered reg_we_in
- br_taken  out  1  branch/jump taken
- br_target  out  ADDR_W  pc+offset (mod 2^ADDR_W)
- busy  out  1  divider iterating

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, result=0, reg_we=0, br_taken=0, br_target=0, busy=0, FSM=IDLE. Any in-flight divide is discarded.
- Handshake:
  - Acceptance happens when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is a combinational function of state and out_ready.
  - Output fields stay stable while out_valid && !out_ready.
  - Simultaneous drain and accept is allowed: the new result replaces the old one with no bubble.
- FSM states: IDLE, DIV, FIN.
  - Accepted non-divide op: stays in IDLE. Result is registered at the next edge, so latency is 1 cycle.
  - ALU ops: shift amount is data_b[log2(XLEN)-1:0]. SLT is signed, SLTU is unsigned; both produce 0 or 1.
  - MUL family: single-cycle 2·XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - Branches: br_taken is evaluated on data_a/data_b (BLT/BGE signed, BLTU/BGEU unsigned; JUMP=1; NONE=0). br_target=pc+offset is always computed. Branch fields are registered together with result.
- Divide ops (md_op 4..7):
  - Divide by zero: resolved in 1 cycle. DIV/DIVU quotient = all ones. REM/REMU = data_a.
  - Signed overflow (data_a = most negative value, data_b = -1, DIV/REM): resolved in 1 cycle. Quotient = data_a, remainder = 0.
  - Otherwise:
    - Operands are latched and converted to magnitudes.
    - The FSM enters DIV with busy=1 and runs a restoring divider for XLEN/DIV_BITS cycles.
    - It then enters FIN, which applies sign correction (quotient negative iff signs differ; remainder takes the dividend's sign) and writes the output register, then returns to IDLE.
    - Total latency from accept to out_valid is XLEN/DIV_BITS + 2 cycles.
- Back-pressure during a divide: in_ready=0 throughout DIV and FIN.
  - The previous result may still drain during this time.
  - If the output register is still occupied when FIN completes, FIN holds until out_valid is 0 or out_ready is 1.
- Wrap-around: br_target and every arithmetic result wrap modulo their width, with no exception signalling.
- rst asserted mid-divide: the divide is aborted, and the next cycle behaves as post-reset.

Test Plan (XLEN=32, DIV_BITS=1):
1. ALU ADD: data_a=0xFFFFFFFF, data_b=2 → out_valid 1 cycle after accept, result=0x00000001. SRA of 0x80000000 by 4 → result=0xF8000000.
2. BLT: data_a=-5, data_b=3, pc=0x100, offset=0xFFFFFFF0 → br_taken=1, br_target=0x000000F0. BLTU with the same operands → br_taken=0.
3. DIV: -7 / 2 → quotient=0xFFFFFFFD after 34 cycles. REM -7 % 2 → 0xFFFFFFFF. in_ready=0 and busy=1 for the duration.
4. Edge divides, each completing in 1 cycle:
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
5. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH -1 × -1 → 0. Run back-to-back with out_ready=1 → one result per cycle, no bubbles.
6. Hold out_ready=0 for 5 cycles → result stable and in_ready=0. Separately, assert rst at cycle 10 of a divide → next cycle out_valid=0, busy=0, in_ready=1.

Source files
------------

// File: rtl/exe_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_md
// Brief    : Execute stage with registered valid/ready output, branch/jump
//            resolution and an RV-M multiply/divide path (iterative divide).
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_md #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int DIV_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              is_md,
  input  logic [3:0]        alu_op,
  input  logic [2:0]        md_op,
  input  logic [2:0]        br_op,
  input  logic [XLEN-1:0]   data_a,
  input  logic [XLEN-1:0]   data_b,
  input  logic [ADDR_W-1:0] offset,
  input  logic              reg_we_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              reg_we,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic              busy
);

  localparam int SHW  = $clog2(XLEN);
  localparam int ITER = XLEN / DIV_BITS;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_FIN = 2'd2} state_t;

  state_t              r_state;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_result;
  logic                r_reg_we;
  logic                r_br_taken;
  logic [ADDR_W-1:0]   r_br_target;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_is_rem;
  logic                r_p_we;
  logic                r_p_taken;
  logic [ADDR_W-1:0]   r_p_target;

  logic                w_accept;
  logic [SHW-1:0]      w_shamt;
  logic [XLEN-1:0]     w_alu;
  logic                w_sa, w_sb;
  logic [2*XLEN-1:0]   w_ma, w_mb, w_prod;
  logic [XLEN-1:0]     w_mul;
  logic                w_dsigned, w_div_zero, w_ovf, w_div_slow;
  logic [XLEN-1:0]     w_fast_div;
  logic [XLEN-1:0]     w_res;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_target;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic [XLEN-1:0]     w_nquo, w_nrem;
  logic [XLEN:0]       w_sh;
  logic [XLEN-1:0]     w_fin_q, w_fin_r;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign reg_we    = r_reg_we;
  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;

  // Integer ALU
  assign w_shamt = data_b[SHW-1:0];
  always_comb begin
    w_alu = '0;
    case (alu_op)
      4'd0:    w_alu = data_a + data_b;
      4'd1:    w_alu = data_a - data_b;
      4'd2:    w_alu = data_a & data_b;
      4'd3:    w_alu = data_a | data_b;
      4'd4:    w_alu = data_a ^ data_b;
      4'd5:    w_alu = data_a << w_shamt;
      4'd6:    w_alu = data_a >> w_shamt;
      4'd7:    w_alu = $unsigned($signed(data_a) >>> w_shamt);
      4'd8:    w_alu = {{(XLEN-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
      4'd9:    w_alu = {{(XLEN-1){1'b0}}, (data_a < data_b)};
      4'd10:   w_alu = data_b;
      default: w_alu = '0;
    endcase
  end

  // Single-cycle multiplier: operands sign/zero-extended to 2*XLEN so one
  // unsigned product covers all four signedness combinations.
  assign w_sa   = (md_op[1:0] == 2'd1) || (md_op[1:0] == 2'd2);
  assign w_sb   = (md_op[1:0] == 2'd1);
  assign w_ma   = {{XLEN{w_sa & data_a[XLEN-1]}}, data_a};
  assign w_mb   = {{XLEN{w_sb & data_b[XLEN-1]}}, data_b};
  assign w_prod = w_ma * w_mb;
  assign w_mul  = (md_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Divide special cases that resolve without iterating
  assign w_dsigned  = !md_op[0];
  assign w_div_zero = (data_b == '0);
  assign w_ovf      = w_dsigned && (data_a == {1'b1, {(XLEN-1){1'b0}}}) && (data_b == '1);
  assign w_div_slow = is_md && md_op[2] && !w_div_zero && !w_ovf;
  always_comb begin
    w_fast_div = '0;
    if (w_div_zero) w_fast_div = md_op[1] ? data_a : '1;
    else            w_fast_div = md_op[1] ? '0 : data_a;
  end

  // Single-cycle result mux
  always_comb begin
    w_res = w_alu;
    if (is_md) w_res = md_op[2] ? w_fast_div : w_mul;
  end

  // Branch resolution
  always_comb begin
    w_taken = 1'b0;
    case (br_op)
      3'd1:    w_taken = (data_a == data_b);
      3'd2:    w_taken = (data_a != data_b);
      3'd3:    w_taken = ($signed(data_a) <  $signed(data_b));
      3'd4:    w_taken = ($signed(data_a) >= $signed(data_b));
      3'd5:    w_taken = (data_a <  data_b);
      3'd6:    w_taken = (data_a >= data_b);
      3'd7:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end
  assign w_target = pc + offset;

  assign w_mag_a = (w_dsigned && data_a[XLEN-1]) ? -data_a : data_a;
  assign w_mag_b = (w_dsigned && data_b[XLEN-1]) ? -data_b : data_b;

  // Restoring divider step: DIV_BITS quotient bits per cycle
  always_comb begin
    w_nquo = r_quo;
    w_nrem = r_rem;
    w_sh   = '0;
    for (int k = 0; k < DIV_BITS; k++) begin
      w_sh   = {w_nrem, w_nquo[XLEN-1]};
      w_nquo = {w_nquo[XLEN-2:0], 1'b0};
      if (w_sh >= {1'b0, r_div}) begin
        w_sh      = w_sh - {1'b0, r_div};
        w_nquo[0] = 1'b1;
      end
      w_nrem = w_sh[XLEN-1:0];
    end
  end

  assign w_fin_q = r_neg_q ? -r_quo : r_quo;
  assign w_fin_r = r_neg_r ? -r_rem : r_rem;

  // Control FSM, divider state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_reg_we    <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_rem    <= 1'b0;
      r_p_we      <= 1'b0;
      r_p_taken   <= 1'b0;
      r_p_target  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_div_slow) begin
            r_quo       <= w_mag_a;
            r_rem       <= '0;
            r_div       <= w_mag_b;
            r_neg_q     <= w_dsigned && (data_a[XLEN-1] ^ data_b[XLEN-1]);
            r_neg_r     <= w_dsigned && data_a[XLEN-1];
            r_is_rem    <= md_op[1];
            r_p_we      <= reg_we_in;
            r_p_taken   <= w_taken;
            r_p_target  <= w_target;
            r_cnt       <= CW'(ITER - 1);
            r_out_valid <= 1'b0;
            r_state     <= S_DIV;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_reg_we    <= reg_we_in;
            r_br_taken  <= w_taken;
            r_br_target <= w_target;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_DIV: begin
          if (out_ready) r_out_valid <= 1'b0;
          r_quo <= w_nquo;
          r_rem <= w_nrem;
          if (r_cnt == '0) r_state <= S_FIN;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_FIN: begin
          if (!r_out_valid || out_ready) begin
            r_out_valid <= 1'b1;
            r_result    <= r_is_rem ? w_fin_r : w_fin_q;
            r_reg_we    <= r_p_we;
            r_br_taken  <= r_p_taken;
            r_br_target <= r_p_target;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_md
// Brief    : Scoreboard bench for exe_stage_md (XLEN=32, DIV_BITS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc;
  logic        is_md;
  logic [3:0]  alu_op;
  logic [2:0]  md_op, br_op;
  logic [31:0] data_a, data_b, offset;
  logic        reg_we_in;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        reg_we, br_taken;
  logic [31:0] br_target;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic        tk;
    logic [31:0] tg;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_id    = 0;

  exe_stage_md #(.XLEN(32), .ADDR_W(32), .DIV_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .is_md(is_md), .alu_op(alu_op), .md_op(md_op), .br_op(br_op),
    .data_a(data_a), .data_b(data_b), .offset(offset), .reg_we_in(reg_we_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .reg_we(reg_we), .br_taken(br_taken), .br_target(br_target), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents one op; pushes its expected response when accepted.
  task automatic issue(input logic md, input logic [3:0] aop, input logic [2:0] mop,
                       input logic [2:0] bop, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] off, input logic we,
                       input logic [31:0] er, input logic etk, input logic push,
                       output int waited);
    exp_t x;
    waited = 0;
    @(negedge clk);
    is_md = md; alu_op = aop; md_op = mop; br_op = bop;
    data_a = a; data_b = b; pc = p; offset = off; reg_we_in = we;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    if (push) begin
      x.res = er; x.we = we; x.tk = etk; x.tg = p + off; x.id = n_id;
      q.push_back(x);
    end
    n_id++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every completed output transfer is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: result=%h with no expected entry", result);
      end else begin
        e = q.pop_front();
        if (result !== e.res || reg_we !== e.we || br_taken !== e.tk || br_target !== e.tg) begin
          n_fail++;
          $display("FAIL op%0d: got res=%h we=%b tk=%b tg=%h expected res=%h we=%b tk=%b tg=%h",
                   e.id, result, reg_we, br_taken, br_target, e.res, e.we, e.tk, e.tg);
        end
      end
    end
  end

  initial begin
    int w;
    int n;
    logic bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pc = '0; is_md = 1'b0;
    alu_op = '0; md_op = '0; br_op = '0; data_a = '0; data_b = '0;
    offset = '0; reg_we_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy",      {63'd0, busy}, 64'd0);
    chk("reset_fields",    {result, reg_we, br_taken, br_target[29:0]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // ALU
    issue(0, 4'd0, 3'd0, 3'd0, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 1, 32'h00000001, 0, 1, w);
    chk("add_latency", {63'd0, out_valid}, 64'd1);
    issue(0, 4'd7, 3'd0, 3'd0, 32'h80000000, 32'd4, 32'h0, 32'h0, 1, 32'hF8000000, 0, 1, w);
    issue(0, 4'd1, 3'd0, 3'd0, 32'd3, 32'd5, 32'h0, 32'h0, 1, 32'hFFFFFFFE, 0, 1, w);
    issue(0, 4'd8, 3'd0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1, 32'd1, 0, 1, w);
    issue(0, 4'd9, 3'd0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1, 32'd0, 0, 1, w);
    issue(0, 4'd5, 3'd0, 3'd0, 32'd1, 32'h3F, 32'h0, 32'h0, 1, 32'h80000000, 0, 1, w);
    issue(0, 4'd10, 3'd0, 3'd0, 32'd9, 32'h1234, 32'h0, 32'h0, 1, 32'h1234, 0, 1, w);
    issue(0, 4'd11, 3'd0, 3'd0, 32'd9, 32'h1234, 32'h0, 32'h0, 1, 32'h0, 0, 1, w);

    // Branches
    issue(0, 4'd0, 3'd0, 3'd3, 32'hFFFFFFFB, 32'd3, 32'h100, 32'hFFFFFFF0, 0, 32'hFFFFFFFE, 1, 1, w);
    issue(0, 4'd0, 3'd0, 3'd5, 32'hFFFFFFFB, 32'd3, 32'h100, 32'hFFFFFFF0, 0, 32'hFFFFFFFE, 0, 1, w);
    issue(0, 4'd0, 3'd0, 3'd7, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 0, 32'h0, 1, 1, w);
    issue(0, 4'd0, 3'd0, 3'd1, 32'd7, 32'd7, 32'h40, 32'h8, 0, 32'd14, 1, 1, w);

    // Iterative divide: latency, busy and back-pressure
    issue(1, 4'd0, 3'd4, 3'd0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 1, 32'hFFFFFFFD, 0, 1, w);
    n = 1; bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (!busy || in_ready) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("div_latency", n, 64'd34);
    chk("div_busy_inready", {63'd0, bad}, 64'd0);
    issue(1, 4'd0, 3'd6, 3'd0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 0, 1, w);
    issue(1, 4'd0, 3'd5, 3'd0, 32'd100, 32'd7, 32'h0, 32'h0, 1, 32'd14, 0, 1, w);
    issue(1, 4'd0, 3'd7, 3'd0, 32'd100, 32'd7, 32'h0, 32'h0, 1, 32'd2, 0, 1, w);
    issue(1, 4'd0, 3'd4, 3'd0, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 32'hFFFFFFFD, 0, 1, w);
    issue(1, 4'd0, 3'd6, 3'd0, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 32'd1, 0, 1, w);

    // Edge divides, single cycle
    issue(1, 4'd0, 3'd5, 3'd0, 32'd5, 32'd0, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 0, 1, w);
    chk("divu0_latency", {63'd0, out_valid}, 64'd1);
    issue(1, 4'd0, 3'd6, 3'd0, 32'd5, 32'd0, 32'h0, 32'h0, 1, 32'd5, 0, 1, w);
    chk("rem0_latency", {63'd0, out_valid}, 64'd1);
    issue(1, 4'd0, 3'd4, 3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'h80000000, 0, 1, w);
    chk("ovf_latency", {63'd0, out_valid}, 64'd1);
    issue(1, 4'd0, 3'd6, 3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'd0, 0, 1, w);

    // Multiplies back-to-back
    issue(1, 4'd0, 3'd3, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'hFFFFFFFE, 0, 1, w);
    issue(1, 4'd0, 3'd1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'd0, 0, 1, w);
    chk("b2b_wait1", w, 64'd0);
    chk("b2b_valid1", {63'd0, out_valid}, 64'd1);
    issue(1, 4'd0, 3'd0, 3'd0, 32'd3, 32'd5, 32'h0, 32'h0, 1, 32'd15, 0, 1, w);
    chk("b2b_wait2", w, 64'd0);
    issue(1, 4'd0, 3'd2, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 0, 1, w);
    chk("b2b_wait3", w, 64'd0);
    chk("b2b_valid3", {63'd0, out_valid}, 64'd1);

    // Output stall
    issue(0, 4'd0, 3'd0, 3'd0, 32'd10, 32'd20, 32'h0, 32'h0, 1, 32'd30, 0, 1, w);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, 32'd30});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of a divide
    issue(1, 4'd0, 3'd4, 3'd0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 1, 32'hFFFFFFFD, 0, 0, w);
    repeat (9) begin @(posedge clk); #1; end
    chk("busy_mid_div", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort", {61'd0, out_valid, busy, in_ready}, 64'd1);
    issue(0, 4'd4, 3'd0, 3'd0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'h0F0F0F0F, 0, 1, w);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
